// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants for the registered ripple-borrow subtractor
package full_subtractor_pkg;
    localparam int DEFAULT_WIDTH = 1;
    localparam int LATENCY       = 1;
endpackage

// File: rtl/fs_bit.sv
// rtl/fs_bit.sv - combinational 1-bit full subtractor cell
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered A - B - Bin with borrow-out; FULL_SUBTRACTOR_OVF_EN adds signed Overflow
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Difference,
`ifdef FULL_SUBTRACTOR_OVF_EN
    output logic             Overflow,
`endif
    output logic             Borrow
);
    logic [WIDTH:0]   w_bw;
    logic [WIDTH-1:0] w_diff;

    logic             r_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    assign w_bw[0] = Bin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            fs_bit u_cell (
                .a    (A[gi]),
                .b    (B[gi]),
                .bin  (w_bw[gi]),
                .d    (w_diff[gi]),
                .bout (w_bw[gi+1])
            );
        end
    endgenerate

    // Results only move on accepted operands; out_valid flags the fresh ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_diff   <= w_diff;
                r_borrow <= w_bw[WIDTH];
            end
        end
    end

`ifdef FULL_SUBTRACTOR_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_bw[WIDTH] ^ w_bw[WIDTH-1];
        end
    end

    assign Overflow = r_ovf;
`endif

    assign out_valid  = r_valid;
    assign Difference = r_diff;
    assign Borrow     = r_borrow;
endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - scoreboard bench for full_subtractor at WIDTH=1 and WIDTH=8
module tb_full_subtractor;
    import full_subtractor_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic       bin      = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [7:0] a8 = '0, b8 = '0;

    logic       ov_valid1, bo1, ov_valid8, bo8;
    logic [0:0] d1;
    logic [7:0] d8;
    logic       of1, of8;

    full_subtractor #(.WIDTH(DEFAULT_WIDTH)) u_w1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a1),
        .B          (b1),
        .Bin        (bin),
        .out_valid  (ov_valid1),
        .Difference (d1),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .Overflow   (of1),
`endif
        .Borrow     (bo1)
    );

    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a8),
        .B          (b8),
        .Bin        (bin),
        .out_valid  (ov_valid8),
        .Difference (d8),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .Overflow   (of8),
`endif
        .Borrow     (bo8)
    );

`ifndef FULL_SUBTRACTOR_OVF_EN
    assign of1 = 1'b0;
    assign of8 = 1'b0;
`endif

    typedef struct {
        bit       v;
        bit [0:0] d1;
        bit       bo1;
        bit       of1;
        bit [7:0] d8;
        bit       bo8;
        bit       of8;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Last accepted result per instance: what the outputs should hold when idle.
    bit [0:0] l_d1;
    bit       l_bo1, l_of1;
    bit [7:0] l_d8;
    bit       l_bo8, l_of8;

    function automatic void ref_sub(input int w, input int a, input int b, input int c,
                                    output int d, output bit bo, output bit of);
        int m, full, sa, sb, sr;
        m    = 1 << w;
        full = a - b - c;
        d    = ((full % m) + m) % m;
        bo   = (a < b + c);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sr   = sa - sb - c;
        of   = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit xa1, input bit xb1, input bit xc,
                         input bit [7:0] xa8, input bit [7:0] xb8);
        exp_t e;
        int   d;
        bit   bo, of;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a1       = xa1;
        b1       = xb1;
        bin      = xc;
        a8       = xa8;
        b8       = xb8;
        if (!r) begin
            e.v  = 1'b0;
            l_d1 = '0; l_bo1 = 0; l_of1 = 0;
            l_d8 = '0; l_bo8 = 0; l_of8 = 0;
        end else begin
            e.v = v;
            if (v) begin
                ref_sub(1, int'(xa1), int'(xb1), int'(xc), d, bo, of);
                l_d1 = d[0:0]; l_bo1 = bo; l_of1 = of;
                ref_sub(8, int'(xa8), int'(xb8), int'(xc), d, bo, of);
                l_d8 = d[7:0]; l_bo8 = bo; l_of8 = of;
            end
        end
        e.d1 = l_d1; e.bo1 = l_bo1; e.of1 = l_of1;
        e.d8 = l_d8; e.bo8 = l_bo8; e.of8 = l_of8;
        q.push_back(e);
    endtask

    task automatic drive_rand(input bit r, input bit v);
        drive(r, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    // Monitor: each entry describes the outputs one edge after its operands were driven.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("w1_valid",  8'(ov_valid1), 8'(e.v));
            chk("w1_diff",   8'(d1),        8'(e.d1));
            chk("w1_borrow", 8'(bo1),       8'(e.bo1));
            chk("w8_valid",  8'(ov_valid8), 8'(e.v));
            chk("w8_diff",   d8,            e.d8);
            chk("w8_borrow", 8'(bo8),       8'(e.bo8));
`ifdef FULL_SUBTRACTOR_OVF_EN
            chk("w1_ovf",    8'(of1),       8'(e.of1));
            chk("w8_ovf",    8'(of8),       8'(e.of8));
`endif
        end
    end

    initial begin
        drive(0, 1, 1, 0, 0, 8'h01, 8'h00);
        drive(0, 1, 1, 0, 0, 8'h01, 8'h00);

        for (int i = 0; i < 8; i++) begin
            bit [2:0] t;
            t = 3'(i);
            drive(1, 1, t[2], t[1], t[0], {7'h00, t[2]}, {7'h00, t[1]});
        end

        drive(1, 1, 1, 0, 0, 8'h01, 8'h00);
        repeat (3) drive(1, 0, 0, 1, 1, 8'h00, 8'hFF);

        repeat (8) drive_rand(1, 1);

        drive(1, 1, 0, 0, 1, 8'h00, 8'h00);
        drive(1, 1, 1, 1, 0, 8'h80, 8'h01);
        drive(1, 1, 0, 1, 0, 8'h7F, 8'hFF);
        drive(1, 1, 1, 1, 1, 8'hFF, 8'hFF);

        repeat (4) drive_rand(1, 1);
        drive_rand(0, 1);
        repeat (2) drive_rand(1, 0);
        repeat (3) drive_rand(1, 1);

        for (int i = 0; i < 60; i++) begin
            drive_rand(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0));
        end
        drive_rand(1, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
